// File: rtl/sram_march_bist.sv
// rtl/sram_march_bist.sv - March C- BIST initiator with functional pass-through for one SRAM bank
module sram_march_bist #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTES  = 4,
    parameter int RED_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bist_en,
    input  logic                  bg_sel,
    input  logic                  reduced_en,
    input  logic [ADDR_WIDTH-1:0] func_a,
    input  logic [DATA_WIDTH-1:0] func_di,
    input  logic [NUM_BYTES-1:0]  func_web,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_di,
    output logic [NUM_BYTES-1:0]  mem_web,
    input  logic [DATA_WIDTH-1:0] mem_do,
    output logic                  bist_busy,
    output logic                  bist_done,
    output logic                  bist_go,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_xor,
    output logic [7:0]            err_cnt
);

    typedef enum logic [2:0] {IDLE, WR_ONLY, RD, WR, RD_ONLY, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt, last_addr, addr_q;
    logic [2:0]            elem, elem_nxt, elem_q;
    logic                  red;
    logic                  down, at_last, issue_rd, running, func_path;
    logic [DATA_WIDTH-1:0] d0, rd_exp, wr_dat, exp_q;
    logic [DATA_WIDTH-1:0] bist_di;
    logic [NUM_BYTES-1:0]  bist_web;
    logic                  rd_valid;

    // E3/E4 walk downwards; E1/E3 write the inverted background, E2/E4 expect it.
    always_comb begin
        last_addr = red ? ADDR_WIDTH'(RED_DEPTH - 1) : {ADDR_WIDTH{1'b1}};
        down      = (elem == 3'd3) || (elem == 3'd4);
        at_last   = down ? (addr == '0) : (addr == last_addr);
        d0        = bg_sel ? ({(DATA_WIDTH/2){2'b01}} ^ {DATA_WIDTH{addr[0]}}) : '0;
        rd_exp    = ((elem == 3'd2) || (elem == 3'd4)) ? ~d0 : d0;
        wr_dat    = ((elem == 3'd1) || (elem == 3'd3)) ? ~d0 : d0;
        running   = (state != IDLE) && (state != DONE);
        func_path = !running;
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        elem_nxt  = elem;
        bist_di   = '0;
        bist_web  = '1;
        issue_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (bist_en) begin
                    state_nxt = WR_ONLY;
                    addr_nxt  = '0;
                    elem_nxt  = 3'd0;
                end
            end
            WR_ONLY: begin
                bist_di  = wr_dat;
                bist_web = '0;
                if (at_last) begin
                    state_nxt = RD;
                    elem_nxt  = 3'd1;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = addr + ADDR_WIDTH'(1);
                end
            end
            RD: begin
                issue_rd  = 1'b1;
                state_nxt = WR;
            end
            WR: begin
                bist_di   = wr_dat;
                bist_web  = '0;
                state_nxt = RD;
                if (at_last) begin
                    elem_nxt = elem + 3'd1;
                    if (elem == 3'd4) begin
                        state_nxt = RD_ONLY;
                        addr_nxt  = '0;
                    end else if (elem == 3'd1) begin
                        addr_nxt = '0;
                    end else begin
                        addr_nxt = last_addr;
                    end
                end else begin
                    addr_nxt = down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
                end
            end
            RD_ONLY: begin
                issue_rd = 1'b1;
                if (at_last) begin
                    state_nxt = DRAIN;
                end else begin
                    addr_nxt = addr + ADDR_WIDTH'(1);
                end
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                if (!bist_en) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (running && !bist_en) begin
            state_nxt = IDLE;
        end
    end

    // The read issued in the abort cycle never gets a compare slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            elem      <= 3'd0;
            red       <= 1'b0;
            rd_valid  <= 1'b0;
            exp_q     <= '0;
            addr_q    <= '0;
            elem_q    <= 3'd0;
            bist_go   <= 1'b1;
            fail_addr <= '0;
            fail_elem <= 3'd0;
            fail_xor  <= '0;
            err_cnt   <= 8'd0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            elem     <= elem_nxt;
            rd_valid <= issue_rd && bist_en;
            if (issue_rd) begin
                exp_q  <= rd_exp;
                addr_q <= addr;
                elem_q <= elem;
            end
            if ((state == IDLE) && bist_en) begin
                red       <= reduced_en;
                bist_go   <= 1'b1;
                fail_addr <= '0;
                fail_elem <= 3'd0;
                fail_xor  <= '0;
                err_cnt   <= 8'd0;
            end else if (rd_valid && (mem_do != exp_q)) begin
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
                bist_go <= 1'b0;
                if (bist_go) begin
                    fail_addr <= addr_q;
                    fail_elem <= elem_q;
                    fail_xor  <= mem_do ^ exp_q;
                end
            end
        end
    end

    assign mem_a     = func_path ? func_a : addr;
    assign mem_di    = func_path ? func_di : bist_di;
    assign mem_web   = rst ? '1 : (func_path ? func_web : bist_web);
    assign bist_busy = running;
    assign bist_done = (state == DONE);

endmodule

// File: tb/tb_sram_march_bist.sv
// tb/tb_sram_march_bist.sv - directed bench for sram_march_bist against a march operation-list model
module tb_sram_march_bist;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bist_en = 1'b0;
    logic        bg_sel = 1'b0;
    logic        reduced_en = 1'b0;
    logic [11:0] func_a = '0;
    logic [31:0] func_di = '0;
    logic [3:0]  func_web = 4'hF;
    logic [11:0] mem_a;
    logic [31:0] mem_di;
    logic [3:0]  mem_web;
    logic [31:0] mem_do;
    logic        bist_busy, bist_done, bist_go;
    logic [11:0] fail_addr;
    logic [2:0]  fail_elem;
    logic [31:0] fail_xor;
    logic [7:0]  err_cnt;

    sram_march_bist dut (
        .clk(clk), .rst(rst), .bist_en(bist_en), .bg_sel(bg_sel), .reduced_en(reduced_en),
        .func_a(func_a), .func_di(func_di), .func_web(func_web),
        .mem_a(mem_a), .mem_di(mem_di), .mem_web(mem_web), .mem_do(mem_do),
        .bist_busy(bist_busy), .bist_done(bist_done), .bist_go(bist_go),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_xor(fail_xor), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // RAM with optional read faults: one stuck-at-1 mask on one address, or all reads zero.
    logic [31:0] ram [0:4095];
    logic        zero_rd = 1'b0;
    logic [11:0] stuck_addr = '0;
    logic [31:0] stuck_mask = '0;

    function automatic logic [31:0] fault_rd(logic [11:0] a, logic [31:0] v);
        if (zero_rd) return 32'h0;
        if (a == stuck_addr) return v | stuck_mask;
        return v;
    endfunction

    always @(posedge clk) begin
        mem_do <= fault_rd(mem_a, ram[mem_a]);
        for (int b = 0; b < 4; b++) begin
            if (!mem_web[b]) ram[mem_a][8*b +: 8] <= mem_di[8*b +: 8];
        end
    end

    typedef struct packed {
        logic [1:0]  kind;
        logic [11:0] a;
        logic [31:0] d;
        logic [2:0]  e;
    } op_t;
    localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_DRAIN = 2'd2;

    op_t         ops[$];
    int          op_idx;
    logic        chk_on = 1'b0;
    logic        run_bad;
    logic [31:0] mdl [0:4095];
    logic        m_go;
    logic [7:0]  m_err;
    logic [11:0] m_fa;
    logic [2:0]  m_fe;
    logic [31:0] m_fx;
    logic [11:0] max_a;
    logic [31:0] e0_d0, e0_d1;
    int          checks = 0;
    int          errors = 0;
    int          cnt;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bg_word(int a, logic bg);
        if (!bg) return 32'h0;
        return (a % 2 == 1) ? 32'hAAAAAAAA : 32'h55555555;
    endfunction

    // March C- as an explicit list of one operation per busy cycle.
    task automatic new_run(int n, logic bg);
        ops.delete();
        for (int a = 0; a < n; a++) ops.push_back({K_WR, 12'(a), bg_word(a, bg), 3'd0});
        for (int e = 1; e <= 4; e++) begin
            for (int i = 0; i < n; i++) begin
                int a = (e < 3) ? i : n - 1 - i;
                logic [31:0] bw = bg_word(a, bg);
                ops.push_back({K_RD, 12'(a), (e == 2 || e == 4) ? ~bw : bw, 3'(e)});
                ops.push_back({K_WR, 12'(a), (e == 1 || e == 3) ? ~bw : bw, 3'(e)});
            end
        end
        for (int a = 0; a < n; a++) ops.push_back({K_RD, 12'(a), bg_word(a, bg), 3'd5});
        ops.push_back({K_DRAIN, 12'd0, 32'd0, 3'd0});
        op_idx = 0; run_bad = 1'b0; max_a = '0;
        m_go = 1'b1; m_err = 8'd0; m_fa = '0; m_fe = 3'd0; m_fx = '0;
    endtask

    task automatic account(op_t p);
        logic [31:0] v = fault_rd(p.a, mdl[p.a]);
        if (v !== p.d) begin
            if (m_err != 8'hFF) m_err++;
            if (m_go) begin
                m_fa = p.a; m_fe = p.e; m_fx = v ^ p.d;
            end
            m_go = 1'b0;
        end
    endtask

    task automatic compare_cycle();
        op_t op;
        logic ok;
        if (!(bist_busy && bist_en)) return;
        if (!run_bad) begin
            checks++;
            if ({bist_go, err_cnt, fail_addr, fail_elem, fail_xor} !== {m_go, m_err, m_fa, m_fe, m_fx}) begin
                errors++; run_bad = 1'b1;
                $display("FAIL stats op=%0d actual go=%0b err=%0d fa=%0h fe=%0d fx=%0h required go=%0b err=%0d fa=%0h fe=%0d fx=%0h",
                         op_idx, bist_go, err_cnt, fail_addr, fail_elem, fail_xor, m_go, m_err, m_fa, m_fe, m_fx);
            end
        end
        if (op_idx >= ops.size()) begin
            if (!run_bad) begin
                checks++; errors++; run_bad = 1'b1;
                $display("FAIL op_overrun actual=%0d required<%0d", op_idx, ops.size());
            end
            return;
        end
        op = ops[op_idx];
        if (op_idx > 0 && ops[op_idx-1].kind == K_RD) account(ops[op_idx-1]);
        if (!run_bad) begin
            ok = ((op.kind == K_DRAIN) || (mem_a === op.a)) &&
                 (mem_web === ((op.kind == K_WR) ? 4'h0 : 4'hF)) &&
                 (mem_di === ((op.kind == K_WR) ? op.d : 32'h0));
            checks++;
            if (!ok) begin
                errors++; run_bad = 1'b1;
                $display("FAIL op[%0d] actual a=%0h web=%0h di=%0h required kind=%0d a=%0h di=%0h",
                         op_idx, mem_a, mem_web, mem_di, op.kind, op.a, op.d);
            end
        end
        if (op.kind == K_WR) mdl[op.a] = op.d;
        if (op_idx == 0) e0_d0 = mem_di;
        if (op_idx == 1) e0_d1 = mem_di;
        if (mem_a > max_a) max_a = mem_a;
        op_idx++;
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_on) compare_cycle();
    endtask

    task automatic run_to_done(int bound);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!bist_done && cnt < bound);
    endtask

    task automatic chk_model_stats(string name);
        chk({name, "_go"}, 64'(bist_go), 64'(m_go));
        chk({name, "_err"}, 64'(err_cnt), 64'(m_err));
        chk({name, "_fa"}, 64'(fail_addr), 64'(m_fa));
        chk({name, "_fe"}, 64'(fail_elem), 64'(m_fe));
        chk({name, "_fx"}, 64'(fail_xor), 64'(m_fx));
    endtask

    initial begin
        // Reset and functional pass-through
        func_web = 4'h0;
        repeat (3) step();
        chk("rst_web", 64'(mem_web), 64'hF);
        chk("rst_busy", 64'(bist_busy), 64'd0);
        chk("rst_done", 64'(bist_done), 64'd0);
        chk("rst_go", 64'(bist_go), 64'd1);
        chk("rst_err", 64'(err_cnt), 64'd0);
        chk("rst_fail", 64'({fail_addr, fail_elem, fail_xor}), 64'd0);
        rst = 1'b0; func_a = 12'h0AB; func_di = 32'hDEADBEEF; func_web = 4'h0;
        #1;
        chk("mux_a", 64'(mem_a), 64'h0AB);
        chk("mux_di", 64'(mem_di), 64'hDEADBEEF);
        chk("mux_web", 64'(mem_web), 64'h0);
        step();
        func_web = 4'hF;
        step();
        chk("func_rd", 64'(mem_do), 64'hDEADBEEF);
        chk("func_done", 64'(bist_done), 64'd0);
        chk("func_go", 64'(bist_go), 64'd1);

        // Stuck-at-1 bit 5 at 0x123: abort at cycle 1000, then a full restart
        stuck_addr = 12'h123; stuck_mask = 32'h20; bg_sel = 1'b0; reduced_en = 1'b0;
        new_run(4096, 1'b0);
        chk_on = 1'b1; bist_en = 1'b1;
        step();
        chk("start_busy", 64'(bist_busy), 64'd1);
        for (int i = 1; i < 1000; i++) step();
        bist_en = 1'b0; func_a = 12'h3C3; func_web = 4'hF;
        step();
        chk("abort_busy", 64'(bist_busy), 64'd0);
        chk("abort_done", 64'(bist_done), 64'd0);
        chk("abort_mux_a", 64'(mem_a), 64'h3C3);
        chk("abort_mux_web", 64'(mem_web), 64'hF);
        new_run(4096, 1'b0);
        bist_en = 1'b1;
        step();
        chk("restart_busy", 64'(bist_busy), 64'd1);
        run_to_done(41000);
        chk("full_latency", 64'(cnt), 64'd40961);
        chk("full_ops_used", 64'(op_idx), 64'(ops.size()));
        chk_model_stats("stuck");
        chk("stuck_go", 64'(bist_go), 64'd0);
        chk("stuck_fa", 64'(fail_addr), 64'h123);
        chk("stuck_fe", 64'(fail_elem), 64'd1);
        chk("stuck_fx", 64'(fail_xor), 64'h20);
        chk("stuck_err", 64'(err_cnt), 64'd3);
        repeat (3) step();
        chk("done_held", 64'({bist_done, bist_busy}), 64'b10);
        func_a = 12'h555; func_di = 32'h1234_5678; func_web = 4'h3;
        #1;
        chk("done_mux", 64'({mem_a, mem_di, mem_web}), 64'({12'h555, 32'h1234_5678, 4'h3}));
        func_web = 4'hF; bist_en = 1'b0;
        step();
        chk("release_done", 64'(bist_done), 64'd0);
        chk("release_err_kept", 64'(err_cnt), 64'd3);
        chk("release_fa_kept", 64'(fail_addr), 64'h123);

        // All reads zero: mismatches in E2/E4 saturate err_cnt
        stuck_mask = '0; zero_rd = 1'b1;
        new_run(4096, 1'b0);
        bist_en = 1'b1;
        step();
        for (int i = 0; i < 13200 && !bist_done; i++) step();
        bist_en = 1'b0;
        step();
        chk("zero_busy", 64'(bist_busy), 64'd0);
        chk_model_stats("zero");
        chk("zero_err", 64'(err_cnt), 64'd255);
        chk("zero_fe", 64'(fail_elem), 64'd2);
        chk("zero_fa", 64'(fail_addr), 64'h000);
        chk("zero_fx", 64'(fail_xor), 64'hFFFFFFFF);
        chk("zero_go", 64'(bist_go), 64'd0);

        // Reset mid-run with errors already counted
        reduced_en = 1'b1;
        new_run(16, 1'b0);
        bist_en = 1'b1;
        step();
        repeat (70) step();
        chk_on = 1'b0; rst = 1'b1; func_web = 4'h0;
        step();
        chk("midrst_busy", 64'(bist_busy), 64'd0);
        chk("midrst_err", 64'(err_cnt), 64'd0);
        chk("midrst_go", 64'(bist_go), 64'd1);
        chk("midrst_web", 64'(mem_web), 64'hF);
        rst = 1'b0; bist_en = 1'b0; func_web = 4'hF; zero_rd = 1'b0;
        step();
        chk_on = 1'b1;

        // Reduced checkerboard, reduced_en changed after start
        bg_sel = 1'b1;
        new_run(16, 1'b1);
        bist_en = 1'b1;
        step();
        reduced_en = 1'b0;
        run_to_done(400);
        chk("red_latency", 64'(cnt), 64'd161);
        chk("red_ops_used", 64'(op_idx), 64'(ops.size()));
        chk_model_stats("red");
        chk("red_go", 64'(bist_go), 64'd1);
        chk("red_err", 64'(err_cnt), 64'd0);
        chk("red_max_a", 64'(max_a), 64'h00F);
        chk("red_e0_a0", 64'(e0_d0), 64'h55555555);
        chk("red_e0_a1", 64'(e0_d1), 64'hAAAAAAAA);
        bist_en = 1'b0;
        step();
        chk("red_release", 64'(bist_done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
